// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor controller ADC feedback path.
package motor_ctrl_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_BITS  = 12;
  localparam logic [1:0]  START_BITS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD
  } sampler_state_t;

  // Command word, MSB first: start, single-ended, channel, then zero padding.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [2:0] ch);
    return {START_BITS, ch, {(FRAME_BITS-5){1'b0}}};
  endfunction

endpackage

// File: rtl/miso_sync.sv
// Two-flop synchroniser for SPI input pins that are asynchronous to clock.
module miso_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; async reset clears both stages to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI master that reads 12-bit ADC conversions for the motor controller.
// Optional build macro ADC_AVG_EN: output a 4-sample running average, with
// sample_valid held off until four frames have completed since the last clear.
module adc_spi_sampler
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned CS_SETUP      = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           channel,
  input  logic                 adc_spi_miso,
  output logic                 adc_clk,
  output logic                 adc_mosi,
  output logic                 adc_cs_n,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int unsigned PW  = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned PHW = $clog2(2 * CLK_DIV);
  localparam int unsigned TW  = $clog2(CS_SETUP + 1);

  sampler_state_t        state;
  logic [PW-1:0]         period_cnt;
  logic                  trigger;
  logic                  pending;
  logic [PHW-1:0]        phase;
  logic [3:0]            bit_idx;
  logic [TW-1:0]         tick;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] next_frame;
  // Only the last DATA_BITS received bits are ever used, so the receive
  // shifter is DATA_BITS wide and the leading bits fall off the top.
  logic [DATA_BITS-1:0]  rx;
  logic                  miso_s;

`ifdef ADC_AVG_EN
  logic [DATA_BITS-1:0]  hist0, hist1, hist2;
  logic [2:0]            fill;
  logic                  enable_q;
  logic [DATA_BITS+1:0]  avg_sum;
`endif

  miso_sync u_miso_sync (
    .clock (clock),
    .reset (reset),
    .d     (adc_spi_miso),
    .q     (miso_s)
  );

  // Trigger on the first enabled cycle and every SAMPLE_PERIOD clocks after.
  always_comb begin
    trigger    = enable && (period_cnt == '0);
    next_frame = build_frame(channel);
  end

  // Period counter: free-runs while enabled, held at zero otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (!enable) begin
      period_cnt <= '0;
    end else if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

`ifdef ADC_AVG_EN
  // Sum of the incoming conversion and the three previous ones, 14 bits wide.
  always_comb begin
    avg_sum = {2'b00, rx} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
  end
`endif

  // Frame sequencer with registered SPI pins, pending flag and sample output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      adc_clk      <= 1'b0;
      adc_mosi     <= 1'b0;
      adc_cs_n     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      pending      <= 1'b0;
      phase        <= '0;
      bit_idx      <= '0;
      tick         <= '0;
      frame        <= '0;
      rx           <= '0;
`ifdef ADC_AVG_EN
      hist0        <= '0;
      hist1        <= '0;
      hist2        <= '0;
      fill         <= '0;
      enable_q     <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      if (!enable) begin
        pending <= 1'b0;
      end else if (trigger && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (enable && (trigger || pending)) begin
            frame    <= next_frame;
            adc_mosi <= next_frame[FRAME_BITS-1];
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            pending  <= 1'b0;
            tick     <= '0;
            state    <= ST_CS_SETUP;
          end
        end

        ST_CS_SETUP: begin
          if (tick == TW'(CS_SETUP - 1)) begin
            phase   <= '0;
            bit_idx <= '0;
            state   <= ST_SHIFT;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (phase == PHW'(2 * CLK_DIV - 1)) begin
            rx       <= {rx[DATA_BITS-2:0], miso_s};
            phase    <= '0;
            adc_clk  <= 1'b0;
            frame    <= frame << 1;
            adc_mosi <= frame[FRAME_BITS-2];
            if (bit_idx == 4'(FRAME_BITS - 1)) begin
              adc_mosi <= 1'b0;
              tick     <= '0;
              state    <= ST_CS_HOLD;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
            if (phase == PHW'(CLK_DIV - 1)) begin
              adc_clk <= 1'b1;
            end
          end
        end

        ST_CS_HOLD: begin
          if (tick == TW'(CS_SETUP - 1)) begin
            adc_cs_n <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
`ifdef ADC_AVG_EN
            hist0 <= rx;
            hist1 <= hist0;
            hist2 <= hist1;
            if (fill != 3'd4) begin
              fill <= fill + 1'b1;
            end
            if (fill >= 3'd3) begin
              sample       <= avg_sum[DATA_BITS+1:2];
              sample_valid <= 1'b1;
            end
`else
            sample       <= rx;
            sample_valid <= 1'b1;
`endif
          end else begin
            tick <= tick + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef ADC_AVG_EN
      // Falling enable restarts the averaging window.
      enable_q <= enable;
      if (enable_q && !enable) begin
        hist0 <= '0;
        hist1 <= '0;
        hist2 <= '0;
        fill  <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler with a behavioural ADC model.
`timescale 1ns/1ps
module tb_adc_spi_sampler;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable;
  logic [2:0]  channel;
  logic        adc_spi_miso = 1'b0;
  logic        adc_clk, adc_mosi, adc_cs_n, sample_valid, busy;
  logic [11:0] sample;

  logic        rst_f, en_f;
  logic        adc_clk_f, adc_mosi_f, cs_n_f, sample_valid_f, busy_f;
  logic [11:0] sample_f;

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(1000), .CS_SETUP(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .channel(channel),
    .adc_spi_miso(adc_spi_miso), .adc_clk(adc_clk), .adc_mosi(adc_mosi),
    .adc_cs_n(adc_cs_n), .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(100), .CS_SETUP(2)) dut_fast (
    .clock(clock), .reset(rst_f), .enable(en_f), .channel(3'd0),
    .adc_spi_miso(1'b1), .adc_clk(adc_clk_f), .adc_mosi(adc_mosi_f),
    .adc_cs_n(cs_n_f), .sample(sample_f), .sample_valid(sample_valid_f), .busy(busy_f)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clock) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ADC model: 4 junk bits then 12 data bits, MSB first, shifted on adc_clk fall.
  logic [11:0] adc_data;
  logic [15:0] resp;
  logic [15:0] mosi_sr;
  int          bit_n;
  always @(negedge adc_cs_n) begin
    resp         = {4'hF, adc_data};
    bit_n        = 0;
    mosi_sr      = '0;
    adc_spi_miso = resp[15];
  end
  always @(negedge adc_clk) begin
    if (!adc_cs_n) begin
      bit_n++;
      if (bit_n < 16) adc_spi_miso = resp[15 - bit_n];
    end
  end
  always @(posedge adc_clk) mosi_sr = {mosi_sr[14:0], adc_mosi};

  // Frame monitor for the main instance.
  logic prev_cs = 1'b1;
  int   low_run = 0, last_low = 0, n_valid = 0, busy_bad = 0;
  always @(negedge clock) begin
    if (sample_valid) n_valid++;
    if (adc_cs_n && busy) busy_bad++;
    if (!adc_cs_n) low_run++;
    else if (!prev_cs) begin
      last_low = low_run;
      low_run  = 0;
    end
    prev_cs = adc_cs_n;
  end

  // Frame monitor for the short-period instance.
  logic prev_cs_f = 1'b1;
  int   rises_f = 0, gaps_f = 0, gap_bad_f = 0, hi_run_f = 0, n_valid_f = 0;
  always @(negedge clock) begin
    if (sample_valid_f) n_valid_f++;
    if (!prev_cs_f && cs_n_f) rises_f++;
    if (cs_n_f) hi_run_f++;
    else if (prev_cs_f && rises_f > 0) begin
      gaps_f++;
      if (hi_run_f != 1) gap_bad_f++;
    end
    if (!cs_n_f) hi_run_f = 0;
    prev_cs_f = cs_n_f;
  end

  task automatic wait_cs(input logic level, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (adc_cs_n === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit          ok;
  int          t_prev, t_now, nv, low_cnt, extra;
  logic [2:0]  ch_tab  [4] = '{3'd1, 3'd7, 3'd0, 3'd2};
  logic [11:0] dat_tab [4] = '{12'h123, 12'hFFF, 12'h000, 12'h5A5};
  logic [11:0] avg_in  [5] = '{12'd100, 12'd200, 12'd300, 12'd400, 12'd500};
  logic [15:0] exp_frame;

  initial begin
    reset = 1'b1; enable = 1'b1; channel = 3'd5; adc_data = 12'hA5C;
    rst_f = 1'b1; en_f = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_cs_n",  adc_cs_n, 1'b1);
    check_eq("rst_clk",   adc_clk, 1'b0);
    check_eq("rst_mosi",  adc_mosi, 1'b0);
    check_eq("rst_sample", sample, 12'h000);
    check_eq("rst_valid", sample_valid, 1'b0);
    check_eq("rst_busy",  busy, 1'b0);

`ifndef ADC_AVG_EN
    // Short period: frames back to back with a single idle cycle.
    rst_f = 1'b0; en_f = 1'b1;
    repeat (900) @(negedge clock);
    en_f = 1'b0;
    repeat (300) @(negedge clock);
    check_eq("fast_frames", rises_f, 7);
    check_eq("fast_valids", n_valid_f, 7);
    check_eq("fast_gaps",   gaps_f, 6);
    check_eq("fast_gap_len_bad", gap_bad_f, 0);
    check_eq("fast_sample", sample_f, 12'hFFF);
    rst_f = 1'b1;

    // First frame after reset.
    reset = 1'b0;
    wait_cs(1'b0, 10, ok);
    check_eq("first_cs_timeout", ok, 1'b1);
    t_prev = cyc;
    check_eq("first_busy", busy, 1'b1);
    wait_valid(300, ok);
    check_eq("first_valid_timeout", ok, 1'b1);
    check_eq("first_sample", sample, 12'hA5C);
    @(negedge clock);
    check_eq("first_valid_width", sample_valid, 1'b0);
    check_eq("first_mosi", mosi_sr, 16'hE800);
    check_eq("first_cs_low", last_low, 132);
    check_eq("first_nvalid", n_valid, 1);

    // Free-running frames; channel is scrambled mid-frame.
    for (int i = 0; i < 4; i++) begin
      channel  = ch_tab[i];
      adc_data = dat_tab[i];
      wait_cs(1'b0, 1100, ok);
      check_eq("run_cs_timeout", ok, 1'b1);
      t_now = cyc;
      check_eq("run_interval", t_now - t_prev, 1000);
      t_prev = t_now;
      repeat (20) @(negedge clock);
      channel = ~ch_tab[i];
      wait_valid(300, ok);
      check_eq("run_valid_timeout", ok, 1'b1);
      check_eq("run_sample", sample, dat_tab[i]);
      @(negedge clock);
      exp_frame = {2'b11, ch_tab[i], 11'b0};
      check_eq("run_mosi", mosi_sr, exp_frame);
      check_eq("run_cs_low", last_low, 132);
    end
    check_eq("busy_between_frames", busy_bad, 0);

    // Enable dropped during bit 7.
    channel = 3'd3; adc_data = 12'h3C3;
    wait_cs(1'b0, 1100, ok);
    check_eq("drop_cs_timeout", ok, 1'b1);
    nv = n_valid;
    repeat (60) @(negedge clock);
    enable = 1'b0;
    wait_valid(200, ok);
    check_eq("drop_valid_timeout", ok, 1'b1);
    check_eq("drop_sample", sample, 12'h3C3);
    low_cnt = 0; extra = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (!adc_cs_n) low_cnt++;
      if (sample_valid) extra++;
    end
    check_eq("drop_cs_quiet", low_cnt, 0);
    check_eq("drop_extra_valid", extra, 0);
    check_eq("drop_one_valid", n_valid - nv, 1);

    // Reset asserted during the high phase of bit 9.
    enable = 1'b1; channel = 3'd5; adc_data = 12'hA5C;
    wait_cs(1'b0, 10, ok);
    check_eq("rst_cs_timeout", ok, 1'b1);
    nv = n_valid;
    repeat (79) @(negedge clock);
    check_eq("pre_rst_clk_high", adc_clk, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_cs_n",   adc_cs_n, 1'b1);
    check_eq("midrst_clk",    adc_clk, 1'b0);
    check_eq("midrst_sample", sample, 12'h000);
    check_eq("midrst_busy",   busy, 1'b0);
    repeat (200) @(negedge clock);
    check_eq("midrst_no_valid", n_valid - nv, 0);
`else
    // Averaging build: valid withheld for three frames, then running mean.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adc_data = avg_in[i];
      wait_cs(1'b0, 1100, ok);
      check_eq("avg_cs_timeout", ok, 1'b1);
      wait_cs(1'b1, 300, ok);
      check_eq("avg_end_timeout", ok, 1'b1);
      if (i < 3) begin
        check_eq("avg_no_valid", sample_valid, 1'b0);
      end else begin
        check_eq("avg_valid", sample_valid, 1'b1);
        check_eq("avg_sample", sample, (i == 3) ? 12'd250 : 12'd350);
      end
    end
    @(negedge clock);
    check_eq("avg_nvalid", n_valid, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
